// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, read-valid strobe and sticky error flags.
module param_sync_fifo #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_rden,
    input  logic                       i_clr_err,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_rdvalid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_alm_full,
    output logic                       o_alm_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              rdvalid_q, rdvalid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              full_c;
    logic              empty_c;
    logic              wr_acc_c;
    logic              rd_acc_c;

    // Status flags decoded from the registered occupancy.
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        empty_c     = (count_q == '0);
        o_full      = full_c;
        o_empty     = empty_c;
        o_alm_full  = (count_q >= CNT_W'(AF_THRESH));
        o_alm_empty = (count_q <= CNT_W'(AE_THRESH));
    end

    // Accept decisions use pre-edge full/empty only; no bypass either way.
    always_comb begin
        wr_acc_c = i_wren && !full_c;
        rd_acc_c = i_rden && !empty_c;
    end

    // Next-state for pointers, count, read port and sticky errors.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rddata_d  = rddata_q;
        rdvalid_d = 1'b0;
        ovf_d     = i_clr_err ? 1'b0 : ovf_q;
        unf_d     = i_clr_err ? 1'b0 : unf_q;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rddata_d  = mem[rd_ptr_q];
            rdvalid_d = 1'b1;
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A violation in the same cycle as a clear keeps the flag set.
        if (i_wren && full_c) begin
            ovf_d = 1'b1;
        end
        if (i_rden && empty_c) begin
            unf_d = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rddata_q  <= rddata_d;
            rdvalid_q <= rdvalid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr_q] <= i_wrdata;
        end
    end

    assign o_rddata    = rddata_q;
    assign o_rdvalid   = rdvalid_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo using a queue scoreboard.
module tb_param_sync_fifo;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF     = 14;
    localparam int unsigned AE     = 2;

    logic              clk;
    logic              rstn;
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic              i_clr_err;
    logic [DATA_W-1:0] o_rddata;
    logic              o_rdvalid;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [4:0]        o_count;
    logic              o_overflow;
    logic              o_underflow;

    param_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_wren     (i_wren),
        .i_wrdata   (i_wrdata),
        .i_rden     (i_rden),
        .i_clr_err  (i_clr_err),
        .o_rddata   (o_rddata),
        .o_rdvalid  (o_rdvalid),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_alm_full (o_alm_full),
        .o_alm_empty(o_alm_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned       n_tests;
    int unsigned       n_fail;
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] m_last;
    logic              m_ovf;
    logic              m_unf;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare all status outputs with the model.
    task automatic check_status();
        int unsigned c;
        c = sb_q.size();
        check("count",     DATA_W'(o_count),     DATA_W'(c));
        check("full",      DATA_W'(o_full),      DATA_W'(c == DEPTH));
        check("empty",     DATA_W'(o_empty),     DATA_W'(c == 0));
        check("alm_full",  DATA_W'(o_alm_full),  DATA_W'(c >= AF));
        check("alm_empty", DATA_W'(o_alm_empty), DATA_W'(c <= AE));
        check("overflow",  DATA_W'(o_overflow),  DATA_W'(m_ovf));
        check("underflow", DATA_W'(o_underflow), DATA_W'(m_unf));
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic wr, input logic [DATA_W-1:0] d,
                         input logic rd, input logic clr);
        logic              m_full;
        logic              m_empty;
        logic              racc;
        logic [DATA_W-1:0] exp_d;
        m_full  = (sb_q.size() == DEPTH);
        m_empty = (sb_q.size() == 0);
        racc    = rd && !m_empty;
        exp_d   = m_last;
        i_wren    = wr;
        i_wrdata  = d;
        i_rden    = rd;
        i_clr_err = clr;
        @(posedge clk);
        #1;
        if (racc) begin
            exp_d  = sb_q.pop_front();
            m_last = exp_d;
        end
        if (wr && !m_full) sb_q.push_back(d);
        m_ovf = (clr ? 1'b0 : m_ovf) | (wr && m_full);
        m_unf = (clr ? 1'b0 : m_unf) | (rd && m_empty);
        check("rdvalid", DATA_W'(o_rdvalid), DATA_W'(racc));
        check("rddata",  o_rddata, exp_d);
        check_status();
        i_wren    = 1'b0;
        i_rden    = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        model_reset();
        rstn      = 1'b0;
        i_wren    = 1'b0;
        i_wrdata  = '0;
        i_rden    = 1'b0;
        i_clr_err = 1'b0;

        // Reset state
        #12;
        check("rst_rddata",  o_rddata, '0);
        check("rst_rdvalid", DATA_W'(o_rdvalid), '0);
        check_status();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill 0..15, then overflow attempt
        for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(99), 1'b0, 1'b0);
        check("ovf_after_fill", DATA_W'(o_overflow), DATA_W'(1));

        // Drain 0..15, then underflow attempt (rddata holds 15)
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("rddata_hold", o_rddata, DATA_W'(15));
        check("unf_after_drain", DATA_W'(o_underflow), DATA_W'(1));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Wrap: advance pointers by 10, then full cycle of A0..AF
        for (int i = 0; i < 10; i++) cycle(1'b1, DATA_W'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(8'hA0 + i), 1'b0, 1'b0);
        check("wrap_full", DATA_W'(o_full), DATA_W'(1));
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous at count=8
        for (int i = 0; i < 8; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        check("simul_count8", DATA_W'(o_count), DATA_W'(8));
        // Simultaneous at full: read wins, write rejected
        for (int i = 0; i < 8; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        check("simul_full_cnt", DATA_W'(o_count), DATA_W'(15));
        check("simul_full_ovf", DATA_W'(o_overflow), DATA_W'(1));
        // Simultaneous at empty: write wins, read rejected
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, DATA_W'(55), 1'b1, 1'b0);
        check("simul_empty_cnt", DATA_W'(o_count), DATA_W'(1));
        check("simul_empty_unf", DATA_W'(o_underflow), DATA_W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Clear with no violation, then clear racing an overflow
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", DATA_W'(o_overflow), '0);
        check("clr_unf", DATA_W'(o_underflow), '0);
        for (int i = 0; i < 16; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        cycle(1'b1, rnd_word(), 1'b0, 1'b1);
        check("clr_vs_ovf", DATA_W'(o_overflow), DATA_W'(1));
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Async reset mid-burst at count=5
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(200 + i), 1'b0, 1'b0);
        i_wren   = 1'b1;
        i_wrdata = DATA_W'(300);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("arst_count", DATA_W'(o_count), '0);
        check("arst_rddata", o_rddata, '0);
        check("arst_rdvalid", DATA_W'(o_rdvalid), '0);
        check_status();
        i_wren = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_unf", DATA_W'(o_underflow), DATA_W'(1));
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
